scan_mux_reg: RTL and testbench

- Parametrised, registered N-channel, W-bit multiplexer; next generation of the team's 4:1 single-bit behavioural mux.
- Adds a clocked output stage, an enable/hold, and an auto-scan mode.
- In auto-scan mode an internal dwell counter steps through the channels. Typical consumer: time-multiplexed seven-segment/LED display drivers on the lab boards.
- Manual mode keeps the classic select-driven mux behaviour, with one cycle of latency.

---
 rtl/scan_mux_reg_pkg.sv | 16 +
 rtl/scan_mux_reg_if.sv | 32 +++
 rtl/scan_mux_reg_scan_ctr.sv | 70 +++++++
 rtl/scan_mux_reg.sv | 95 +++++++++
 tb/tb_scan_mux_reg.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/scan_mux_reg_pkg.sv
// Shared definitions for the registered scanning multiplexer:
// mode encodings and the index-width helper used by every file.
package scan_mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Width needed to hold an index in [0, n-1]; never less than one bit
    // so that degenerate sizes still produce a legal vector.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_mux_reg_if.sv
// Bus bundle between the channel source / display consumer and the
// registered scanning multiplexer.
interface scan_mux_reg_if
    import scan_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);

    localparam int SEL_W = idx_width(N_CH);

    logic                  en;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [N_CH*WIDTH-1:0] data_in;
    logic [WIDTH-1:0]      data_out;
    logic [SEL_W-1:0]      ch_out;
    logic                  wrap;

    // Producer side: drives control and channel data, observes the output.
    modport master (
        output en, mode, sel, data_in,
        input  data_out, ch_out, wrap
    );

    // Multiplexer side.
    modport slave (
        input  en, mode, sel, data_in,
        output data_out, ch_out, wrap
    );

endinterface

// File: rtl/scan_mux_reg_scan_ctr.sv
// Scan sequencer: dwell counter, channel pointer and wrap pulse.
// The pointer is restarted on scan entry and otherwise advances once
// every SCAN_DIV enabled cycles while scanning.
module scan_ctr
    import scan_mux_pkg::*;
#(
    parameter  int N_CH     = 4,
    parameter  int SCAN_DIV = 4,
    localparam int SEL_W    = idx_width(N_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             entry_i,
    input  logic             run_i,
    output logic [SEL_W-1:0] ptr_o,
    output logic             wrap_o
);

    localparam int CNT_W = idx_width(SCAN_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N_CH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             wrap_q, wrap_d;

    // Next-state: restart on entry, step the dwell while running, else hold.
    always_comb begin
        cnt_d  = cnt_q;
        ptr_d  = ptr_q;
        wrap_d = 1'b0;
        if (en_i) begin
            if (entry_i) begin
                cnt_d = '0;
                ptr_d = '0;
            end else if (run_i) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (ptr_q == PTR_LAST) begin
                        ptr_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + SEL_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Sequencer state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            ptr_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
            wrap_q <= wrap_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/scan_mux_reg.sv
// Registered N-channel multiplexer with clock enable and an auto-scan
// mode that cycles through the channels (e.g. multiplexed LED displays).
// Every output is a flop; there is no combinational input-to-output path.
module scan_mux_reg
    import scan_mux_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int WIDTH    = 8,
    parameter int SCAN_DIV = 4
) (
    input  logic          clk,
    input  logic          reset,
    scan_mux_reg_if.slave bus
);

    localparam int SEL_W = idx_width(N_CH);

    // Channel picker; indices beyond the last channel yield zero, which
    // covers the unused codes when N_CH is not a power of two.
    function automatic logic [WIDTH-1:0] pick(
        input logic [N_CH*WIDTH-1:0] d,
        input logic [SEL_W-1:0]      idx
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(idx) == k) r = d[k*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    mode_e            mode_in;
    mode_e            mode_q;
    logic             scan_entry;
    logic             scan_run;
    logic [SEL_W-1:0] ptr;
    logic             wrap;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] ch_q, ch_d;

    assign mode_in    = mode_e'(bus.mode);
    // Entry is a mode edge, detected against the previous edge's mode even
    // when disabled, so a deferred entry is never re-detected later.
    assign scan_entry = (mode_in == MODE_SCAN) && (mode_q == MODE_MANUAL);
    assign scan_run   = (mode_in == MODE_SCAN) && (mode_q == MODE_SCAN);

    scan_ctr #(
        .N_CH     (N_CH),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_ctr (
        .clk     (clk),
        .reset   (reset),
        .en_i    (bus.en),
        .entry_i (scan_entry),
        .run_i   (scan_run),
        .ptr_o   (ptr),
        .wrap_o  (wrap)
    );

    // Output-stage next state: select-driven, scan restart, or scan pointer.
    always_comb begin
        data_d = data_q;
        ch_d   = ch_q;
        if (bus.en) begin
            if (mode_in == MODE_MANUAL) begin
                data_d = pick(bus.data_in, bus.sel);
                ch_d   = bus.sel;
            end else if (scan_entry) begin
                data_d = pick(bus.data_in, SEL_W'(0));
                ch_d   = '0;
            end else begin
                data_d = pick(bus.data_in, ptr);
                ch_d   = ptr;
            end
        end
    end

    // Output and mode-history registers; mode_q ignores the enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_MANUAL;
            data_q <= '0;
            ch_q   <= '0;
        end else begin
            mode_q <= mode_in;
            data_q <= data_d;
            ch_q   <= ch_d;
        end
    end

    assign bus.data_out = data_q;
    assign bus.ch_out   = ch_q;
    assign bus.wrap     = wrap;

endmodule

// File: tb/tb_scan_mux_reg.sv
module tb_scan_mux_reg;

    localparam int N_CH     = 4;
    localparam int WIDTH    = 8;
    localparam int SCAN_DIV = 3;
    localparam logic [31:0] BASE = 32'hDDCCBBAA;

    logic clk;
    logic reset;

    scan_mux_reg_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

    scan_mux_reg #(
        .N_CH     (N_CH),
        .WIDTH    (WIDTH),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Reference model: scanning expressed as the number of steady enabled
    // scan cycles since the last entry.
    int         m_k;
    bit         m_prev;
    logic [7:0] m_data;
    int         m_ch;
    bit         m_wrap;

    function automatic logic [7:0] chan(input logic [31:0] d, input int idx);
        logic [7:0] r;
        r = (idx < N_CH) ? d[idx*8 +: 8] : 8'h00;
        return r;
    endfunction

    task automatic model_reset();
        m_k = 0; m_prev = 1'b0; m_data = 8'h00; m_ch = 0; m_wrap = 1'b0;
    endtask

    task automatic model_step();
        if (bus.en) begin
            if (!bus.mode) begin
                m_data = chan(bus.data_in, int'(bus.sel));
                m_ch   = int'(bus.sel);
                m_wrap = 1'b0;
            end else if (!m_prev) begin
                m_k = 0; m_data = chan(bus.data_in, 0); m_ch = 0; m_wrap = 1'b0;
            end else begin
                m_ch   = (m_k / SCAN_DIV) % N_CH;
                m_data = chan(bus.data_in, m_ch);
                m_k    = m_k + 1;
                m_wrap = (m_k % (SCAN_DIV * N_CH)) == 0;
            end
        end else begin
            m_wrap = 1'b0;
        end
        m_prev = bus.mode;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".data_out"}, 32'(bus.data_out), 32'(m_data));
        check({tag, ".ch_out"},   32'(bus.ch_out),   32'(m_ch));
        check({tag, ".wrap"},     32'(bus.wrap),     32'(m_wrap));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic       en;
        logic       mode;
        logic [1:0] sel;
        logic [7:0] exp_data;
        logic [1:0] exp_ch;
        logic       exp_wrap;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic en, input logic mode, input logic [1:0] sel,
                       input logic [7:0] d, input logic [1:0] c, input logic w);
        vec_t v;
        v.en = en; v.mode = mode; v.sel = sel;
        v.exp_data = d; v.exp_ch = c; v.exp_wrap = w;
        tbl.push_back(v);
    endtask

    initial begin
        int cnt2;
        int guard;
        int ch;
        logic [7:0] vals [4];

        vals[0] = 8'hAA; vals[1] = 8'hBB; vals[2] = 8'hCC; vals[3] = 8'hDD;

        // Manual select, then hold with en=0 while sel toggles.
        add(1'b1, 1'b0, 2'd2, 8'hCC, 2'd2, 1'b0);
        add(1'b1, 1'b0, 2'd0, 8'hAA, 2'd0, 1'b0);
        for (int i = 0; i < 5; i++)
            add(1'b0, 1'b0, (i % 2 == 0) ? 2'd1 : 2'd3, 8'hAA, 2'd0, 1'b0);
        // Scan from entry: channel 0 for SCAN_DIV+1 cycles, then SCAN_DIV each.
        for (int i = 0; i < 14; i++) begin
            ch = (i < 4) ? 0 : ((i - 4) / 3 + 1) % 4;
            add(1'b1, 1'b1, 2'd0, vals[ch], 2'(ch), (i == 12));
        end

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus.en = 1'b0; bus.mode = 1'b0; bus.sel = '0; bus.data_in = BASE;
        model_reset();

        // Asynchronous reset between clock edges.
        #2 reset = 1'b1;
        #1;
        check("init_reset.data_out", 32'(bus.data_out), 32'h0);
        check("init_reset.ch_out",   32'(bus.ch_out),   32'h0);
        check("init_reset.wrap",     32'(bus.wrap),     32'h0);
        #9 reset = 1'b0;

        foreach (tbl[i]) begin
            bus.en = tbl[i].en; bus.mode = tbl[i].mode; bus.sel = tbl[i].sel;
            tick();
            check($sformatf("vec%0d.data_out", i), 32'(bus.data_out), 32'(tbl[i].exp_data));
            check($sformatf("vec%0d.ch_out", i),   32'(bus.ch_out),   32'(tbl[i].exp_ch));
            check($sformatf("vec%0d.wrap", i),     32'(bus.wrap),     32'(tbl[i].exp_wrap));
        end

        // Live data on the current channel is picked up on the next edge.
        check("pre_live.ch_out", 32'(bus.ch_out), 32'h0);
        bus.data_in[7:0] = 8'h55;
        tick();
        check("live.data_out", 32'(bus.data_out), 32'h55);
        check_model("live");

        // Enable dropped mid-dwell on channel 2.
        cnt2  = 0;
        guard = 0;
        bus.en = 1'b1;
        do begin
            tick(); check_model("seek2"); guard++;
        end while (bus.ch_out != 2'd2 && guard < 20);
        check("seek2.reached", 32'(bus.ch_out), 32'd2);
        cnt2 = 1;
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.sel = 2'(i);
            tick();
            check_model("hold");
            check("hold.ch_out", 32'(bus.ch_out), 32'd2);
        end
        bus.en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(); check_model("resume");
            if (bus.ch_out == 2'd2) cnt2++;
            else break;
        end
        check("dwell_ch2", 32'(cnt2), 32'd3);

        // Asynchronous reset mid-scan, then re-entry after release.
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        model_reset();
        check("mid_reset.data_out", 32'(bus.data_out), 32'h0);
        check("mid_reset.ch_out",   32'(bus.ch_out),   32'h0);
        check("mid_reset.wrap",     32'(bus.wrap),     32'h0);
        #2 reset = 1'b0;
        bus.en = 1'b1; bus.mode = 1'b1;
        tick();
        check_model("reentry");
        check("reentry.data_out", 32'(bus.data_out), 32'h55);

        // Randomized traffic against the model.
        bus.data_in = BASE;
        for (int i = 0; i < 400; i++) begin
            bus.en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
            bus.sel = 2'($urandom);
            if ($urandom_range(0, 3) == 0) bus.data_in = $urandom;
            tick();
            check_model($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
